regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter RWIDTH SHALL be: RWIDTH, default 6, register address width.
REQ-002 Parameter DWIDTH SHALL be: DWIDTH, default 32, register data width.
REQ-003 Port clk SHALL be: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port rst_n SHALL be: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port clr_req SHALL be: clr_req  input  1  request to re-run the register clear sequence.
REQ-006 Port a_valid SHALL be: a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-007 Port a_addr SHALL be: a_addr  input  RWIDTH  requester A destination register.
REQ-008 Port a_data SHALL be: a_data  input  DWIDTH  requester A write data.
REQ-009 Port a_ready SHALL be: a_ready  output  1  requester A write accepted this cycle.
REQ-010 Ports b_valid, b_addr, b_data, b_ready SHALL mirror REQ-006..009 for requester B (load writeback).
REQ-011 Port we SHALL be: we  output  1  register file write enable, registered.
REQ-012 Port wa SHALL be: wa  output  RWIDTH  register file write address, registered.
REQ-013 Port wd SHALL be: wd  output  DWIDTH  register file write data, registered.
REQ-014 Port busy SHALL be: busy  output  1  high while in CLEAR state.

Function
REQ-015 The block SHALL have two states, CLEAR and RUN, plus a clear counter cnt (RWIDTH bits) and a last-grant flag lg (A or B).
REQ-016 In CLEAR, each clock SHALL register we=1, wa=cnt, wd=0 and increment cnt.
REQ-017 In CLEAR, when cnt equals 2**RWIDTH-1 the block SHALL issue that write and move to RUN on the same edge; cnt SHALL then reload to 1.
REQ-018 In CLEAR, a_ready and b_ready SHALL be 0; clr_req SHALL be ignored (no restart of cnt).
REQ-019 busy SHALL equal (state==CLEAR), combinationally from the state register.
REQ-020 In RUN, ready SHALL be combinational: if only one requester is valid, that requester's ready=1.
REQ-021 In RUN, if both are valid, the requester not equal to lg SHALL get ready=1; the other SHALL get ready=0.
REQ-022 A handshake (valid & ready) SHALL update lg to the granted requester; with no handshake lg SHALL hold.
REQ-023 Latency: a handshake at edge N SHALL appear as we/wa/wd at outputs after edge N (one cycle).
REQ-024 A handshake with address 0 SHALL be accepted (ready=1) but SHALL register we=0; lg still updates.
REQ-025 In RUN with no handshake, we SHALL register 0; wa/wd SHALL hold their previous values.
REQ-026 Both requesters valid with the same address SHALL be handled as a normal tie; no merging; loser retries next cycle.
REQ-027 clr_req=1 in RUN SHALL force both readies to 0 that cycle, register we=0, and enter CLEAR with cnt=1 at the next edge.
REQ-028 Requesters SHALL hold valid/addr/data stable until ready; the block need not tolerate withdrawal.

Reset
REQ-029 rst_n=0 at a rising edge SHALL set state=CLEAR, cnt=1, lg=B, we=0, wa=0, wd=0.
REQ-030 During reset, busy SHALL read 1 and both readies SHALL read 0.
REQ-031 Reset asserted mid-CLEAR or mid-RUN SHALL abandon the operation; the clear sequence restarts at address 1.
REQ-032 The first clear write (wa=1) SHALL appear after the first edge with rst_n=1; RUN is entered after 2**RWIDTH-1 such edges (63 at default).

Verification
REQ-033 Reset release, no requests -> we=1 for 63 cycles with wa=1..63, wd=0; busy falls after cycle 63; then we=0.
REQ-034 RUN, a_valid only, a_addr=5, a_data=0xDEADBEEF -> a_ready=1 same cycle; next cycle we=1, wa=5, wd=0xDEADBEEF.
REQ-035 RUN after reset, both valid every cycle (A: addr 3, B: addr 4) -> grants A, B, A, B...; wa sequence 3,4,3,4.
REQ-036 RUN, b_valid with b_addr=0 -> b_ready=1; next cycle we=0; next tie grants A.
REQ-037 RUN, clr_req=1 with a_valid=1 -> a_ready=0; busy=1 next cycle; 63 clear writes; then A accepted.
REQ-038 rst_n=0 for one edge when wa=20 in CLEAR -> we=0, wa=0; after release clear restarts at wa=1.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Register file write-port arbiter: clears every register (addresses 1..2**RWIDTH-1) after reset
// or on request, then round-robins writebacks from two requesters onto one registered write port.
module regfile_wr_arbiter #(
    parameter int unsigned RWIDTH = 6,
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    input  logic              a_valid,
    input  logic [RWIDTH-1:0] a_addr,
    input  logic [DWIDTH-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [RWIDTH-1:0] b_addr,
    input  logic [DWIDTH-1:0] b_data,
    output logic              b_ready,
    output logic              we,
    output logic [RWIDTH-1:0] wa,
    output logic [DWIDTH-1:0] wd,
    output logic              busy
);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    localparam logic [RWIDTH-1:0] CntMax = '1;
    localparam logic [RWIDTH-1:0] CntOne = RWIDTH'(1);
    localparam logic              LgA    = 1'b0;
    localparam logic              LgB    = 1'b1;

    state_e            state_q, state_d;
    logic [RWIDTH-1:0] cnt_q, cnt_d;
    logic              lg_q, lg_d;
    logic              we_q, we_d;
    logic [RWIDTH-1:0] wa_q, wa_d;
    logic [DWIDTH-1:0] wd_q, wd_d;

    // State register and registered write port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StClear;
            cnt_q   <= CntOne;
            lg_q    <= LgB;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lg_q    <= lg_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClear: if (cnt_q == CntMax) state_d = StRun;
            StRun:   if (clr_req)         state_d = StClear;
            default: state_d = StClear;
        endcase
    end

    // Outputs and datapath next values
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        cnt_d   = cnt_q;
        lg_d    = lg_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        unique case (state_q)
            StClear: begin
                we_d  = 1'b1;
                wa_d  = cnt_q;
                wd_d  = '0;
                cnt_d = (cnt_q == CntMax) ? CntOne : cnt_q + CntOne;
            end
            StRun: begin
                if (clr_req) begin
                    cnt_d = CntOne;
                end else if (rst_n) begin
                    // On a tie the requester that did not win last time goes first
                    a_ready = a_valid && (!b_valid || (lg_q == LgB));
                    b_ready = b_valid && (!a_valid || (lg_q == LgA));
                    if (a_ready) begin
                        lg_d = LgA;
                        if (a_addr != '0) begin
                            we_d = 1'b1;
                            wa_d = a_addr;
                            wd_d = a_data;
                        end
                    end else if (b_ready) begin
                        lg_d = LgB;
                        if (b_addr != '0) begin
                            we_d = 1'b1;
                            wa_d = b_addr;
                            wd_d = b_data;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy = (state_q == StClear);
    assign we   = we_q;
    assign wa   = wa_q;
    assign wd   = wd_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter at default widths.
module tb_regfile_wr_arbiter;

    localparam int RW = 6;
    localparam int DW = 32;
    localparam int NCLR = 63;

    logic          clk = 1'b0;
    logic          rst_n, clr_req;
    logic          a_valid, b_valid, a_ready, b_ready;
    logic [RW-1:0] a_addr, b_addr, wa;
    logic [DW-1:0] a_data, b_data, wd;
    logic          we, busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.RWIDTH(RW), .DWIDTH(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_req(clr_req),
        .a_valid(a_valid),
        .a_addr (a_addr),
        .a_data (a_data),
        .a_ready(a_ready),
        .b_valid(b_valid),
        .b_addr (b_addr),
        .b_data (b_data),
        .b_ready(b_ready),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .busy   (busy)
    );

    // Advance one rising edge; sample 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr_req = 1'b0;
        a_valid = 1'b1; a_addr = 6'd7; a_data = 32'h1111_1111;
        b_valid = 1'b1; b_addr = 6'd8; b_data = 32'h2222_2222;
        tick(); tick();
        n_tests++;
        if (we !== 1'b0 || wa !== 6'd0 || wd !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_port: we=%b wa=%0d wd=%h, want 0/0/0", we, wa, wd);
        end
        n_tests++;
        if (busy !== 1'b1 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b a_ready=%b b_ready=%b, want 1/0/0",
                     busy, a_ready, b_ready);
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_clear_seq();
        rst_n = 1'b1;
        for (int i = 1; i <= NCLR; i++) begin
            tick();
            n_tests++;
            if (we !== 1'b1 || wa !== RW'(i) || wd !== 32'd0 || busy !== (i < NCLR)) begin
                n_fail++;
                $display("FAIL clear_write%0d: we=%b wa=%0d wd=%h busy=%b, want 1/%0d/0/%b",
                         i, we, wa, wd, busy, i, i < NCLR);
            end
        end
        tick();
        n_tests++;
        if (we !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_done: we=%b busy=%b, want 0/0", we, busy);
        end
    endtask

    task automatic test_tie();
        logic [RW-1:0] exp_wa [4];
        exp_wa[0] = 6'd3; exp_wa[1] = 6'd4; exp_wa[2] = 6'd3; exp_wa[3] = 6'd4;
        a_valid = 1'b1; a_addr = 6'd3; a_data = 32'hAAAA_0003;
        b_valid = 1'b1; b_addr = 6'd4; b_data = 32'hBBBB_0004;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
                n_fail++;
                $display("FAIL tie_grant%0d: a_ready=%b b_ready=%b, want %b/%b",
                         i, a_ready, b_ready, i % 2 == 0, i % 2 == 1);
            end
            tick();
            n_tests++;
            if (we !== 1'b1 || wa !== exp_wa[i] ||
                wd !== ((i % 2 == 0) ? 32'hAAAA_0003 : 32'hBBBB_0004)) begin
                n_fail++;
                $display("FAIL tie_write%0d: we=%b wa=%0d wd=%h, want 1/%0d", i, we, wa, wd,
                         exp_wa[i]);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_single_a();
        a_valid = 1'b1; a_addr = 6'd5; a_data = 32'hDEAD_BEEF;
        #1;
        n_tests++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ready: a_ready=%b b_ready=%b, want 1/0", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0;
        n_tests++;
        if (we !== 1'b1 || wa !== 6'd5 || wd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_write: we=%b wa=%0d wd=%h, want 1/5/deadbeef", we, wa, wd);
        end
        tick();
        n_tests++;
        if (we !== 1'b0 || wa !== 6'd5 || wd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL idle_hold: we=%b wa=%0d wd=%h, want 0/5/deadbeef", we, wa, wd);
        end
    endtask

    task automatic test_addr_zero();
        b_valid = 1'b1; b_addr = 6'd0; b_data = 32'h5555_5555;
        #1;
        n_tests++;
        if (b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_ready: b_ready=%b, want 1", b_ready);
        end
        tick();
        b_valid = 1'b0;
        n_tests++;
        if (we !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_we: we=%b, want 0", we);
        end
        // lg was A before; the address-0 grant to B must make A win the next tie
        a_valid = 1'b1; a_addr = 6'd9; a_data = 32'h0000_0009;
        b_valid = 1'b1; b_addr = 6'd10; b_data = 32'h0000_000A;
        #1;
        n_tests++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_lg: a_ready=%b b_ready=%b, want 1/0", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        n_tests++;
        if (we !== 1'b1 || wa !== 6'd9) begin
            n_fail++;
            $display("FAIL zero_next: we=%b wa=%0d, want 1/9", we, wa);
        end
    endtask

    task automatic test_clr_req();
        a_valid = 1'b1; a_addr = 6'd12; a_data = 32'hC0FF_EE12;
        clr_req = 1'b1;
        #1;
        n_tests++;
        if (a_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_ready: a_ready=%b busy=%b, want 0/0", a_ready, busy);
        end
        tick();
        clr_req = 1'b0;
        n_tests++;
        if (we !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_enter: we=%b busy=%b, want 0/1", we, busy);
        end
        for (int i = 1; i <= NCLR; i++) begin
            clr_req = (i == 10); // must not restart the sequence
            #1;
            if (a_ready !== 1'b0) begin
                n_tests++;
                n_fail++;
                $display("FAIL clr_ready_clear%0d: a_ready=%b, want 0", i, a_ready);
            end
            tick();
            n_tests++;
            if (we !== 1'b1 || wa !== RW'(i) || wd !== 32'd0) begin
                n_fail++;
                $display("FAIL reclear%0d: we=%b wa=%0d wd=%h, want 1/%0d/0", i, we, wa, wd, i);
            end
        end
        clr_req = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_exit: busy=%b a_ready=%b, want 0/1", busy, a_ready);
        end
        tick();
        a_valid = 1'b0;
        n_tests++;
        if (we !== 1'b1 || wa !== 6'd12 || wd !== 32'hC0FF_EE12) begin
            n_fail++;
            $display("FAIL clr_after: we=%b wa=%0d wd=%h, want 1/12/c0ffee12", we, wa, wd);
        end
    endtask

    task automatic test_mid_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        n_tests++;
        if (wa !== 6'd20 || we !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: we=%b wa=%0d, want 1/20", we, wa);
        end
        rst_n = 1'b0;
        tick();
        n_tests++;
        if (we !== 1'b0 || wa !== 6'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_hold: we=%b wa=%0d busy=%b, want 0/0/1", we, wa, busy);
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (we !== 1'b1 || wa !== 6'd1) begin
            n_fail++;
            $display("FAIL midrst_restart: we=%b wa=%0d, want 1/1", we, wa);
        end
        tick();
        n_tests++;
        if (wa !== 6'd2) begin
            n_fail++;
            $display("FAIL midrst_second: wa=%0d, want 2", wa);
        end
    endtask

    initial begin
        test_reset();
        test_clear_seq();
        test_tie();
        test_single_a();
        test_addr_zero();
        test_clr_req();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
